conv2d_stream_engine: RTL and testbench

Parametrised 3×3 streaming 2-D convolution engine with a runtime-loadable signed kernel and valid/ready handshakes on both sides. It is the next-generation convolution front end of the NPU datapath. It accepts one raster-order frame of unsigned pixels per `start` and emits one signed result per fully populated window ("valid" convolution, no padding). Output backpressure stalls the whole pipeline.

---
 rtl/conv2d_stream_engine_pkg.sv | 24 ++
 rtl/conv2d_stream_engine_if.sv | 37 +++
 rtl/conv2d_stream_engine_line_buffer.sv | 82 ++++++++
 rtl/conv2d_stream_engine.sv | 139 +++++++++++++
 tb/tb_conv2d_stream_engine.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv2d_stream_engine_pkg.sv
// Shared types and constants for the 3x3 streaming convolution engine.
// Optional build macro CONV_RELU_EN is consumed by the top module.
package conv_pkg;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    localparam int LATENCY = 3;

    // Sobel-x, row-major: {1,0,-1; 2,0,-2; 1,0,-1}
    function automatic int sobel_x(input int i);
        case (i)
            0, 6:    return 1;
            2, 8:    return -1;
            3:       return 2;
            5:       return -2;
            default: return 0;
        endcase
    endfunction

    function automatic int conv_acc_w(input int dw, input int cw);
        return dw + cw + 5;
    endfunction

endpackage

// File: rtl/conv2d_stream_engine_if.sv
// Control, kernel-load and pixel/result handshake bundle of the engine.
// master drives requests and pixels; slave is the engine itself.
interface conv2d_stream_engine_if
    import conv_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int ACC_W  = conv_acc_w(DATA_W, COEF_W)
);
    logic              start;
    logic              coef_wr;
    logic [3:0]        coef_addr;
    logic [COEF_W-1:0] coef_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_data;
    logic              out_last;
    logic              busy;
    logic              done;

    modport master (
        output start, coef_wr, coef_addr, coef_data,
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last,
        input  busy, done
    );

    modport slave (
        input  start, coef_wr, coef_addr, coef_data,
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last,
        output busy, done
    );
endinterface

// File: rtl/conv2d_stream_engine_line_buffer.sv
// Two row buffers, 3x3 window register and raster x/y tracking.
// Column 2 of the window is the newest pixel; row 2 is the current row.
module conv_line_buffer
    import conv_pkg::*;
#(
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32,
    parameter int DATA_W = 8
)(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    input  logic                          en,
    input  logic                          accept,
    input  logic [DATA_W-1:0]             pix,
    output logic [2:0][2:0][DATA_W-1:0]   win,
    output logic                          win_valid,
    output logic                          win_last,
    output logic                          last_pix
);
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);

    logic [DATA_W-1:0] row0 [IMG_W];
    logic [DATA_W-1:0] row1 [IMG_W];
    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic              x_end;
    logic              y_end;
    logic              in_window;

    assign x_end     = x == XW'(IMG_W - 1);
    assign y_end     = y == YW'(IMG_H - 1);
    assign last_pix  = x_end && y_end;
    assign in_window = (x >= XW'(2)) && (y >= YW'(2));

    // Row storage is never reset; both rows are filled before first use.
    always_ff @(posedge clk) begin
        if (accept) begin
            row0[x] <= row1[x];
            row1[x] <= pix;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x <= '0;
            y <= '0;
        end else if (clear) begin
            x <= '0;
            y <= '0;
        end else if (accept) begin
            if (x_end) begin
                x <= '0;
                y <= y_end ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win       <= '0;
            win_valid <= 1'b0;
            win_last  <= 1'b0;
        end else if (en) begin
            win_valid <= accept && in_window;
            win_last  <= accept && last_pix;
            if (accept) begin
                for (int r = 0; r < 3; r++) begin
                    win[r][0] <= win[r][1];
                    win[r][1] <= win[r][2];
                end
                win[0][2] <= row0[x];
                win[1][2] <= row1[x];
                win[2][2] <= pix;
            end
        end
    end

endmodule

// File: rtl/conv2d_stream_engine.sv
// 3x3 valid-mode streaming convolution with loadable signed kernel.
// Define CONV_RELU_EN to clamp negative results to zero.
module conv2d_stream_engine
    import conv_pkg::*;
#(
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32,
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int ACC_W  = conv_acc_w(DATA_W, COEF_W)
)(
    input  logic                  clk,
    input  logic                  rst,
    conv2d_stream_engine_if.slave bus
);
    localparam int P_W = DATA_W + COEF_W + 1;

    state_t                       state;
    state_t                       state_nx;
    logic                         en;
    logic                         accept;
    logic                         last_pix;
    logic                         flush_end;
    logic [COEF_W-1:0]            kern [9];
    logic [2:0][2:0][DATA_W-1:0]  win;
    logic                         win_valid;
    logic                         win_last;
    logic signed [P_W-1:0]        prod [9];
    logic                         prod_valid;
    logic                         prod_last;
    logic signed [ACC_W-1:0]      rsum [3];
    logic                         sum_valid;
    logic                         sum_last;
    logic signed [ACC_W-1:0]      total;
    logic signed [ACC_W-1:0]      result;

    function automatic logic signed [P_W-1:0] mul(
        input logic [DATA_W-1:0] p,
        input logic [COEF_W-1:0] k
    );
        logic signed [P_W-1:0] a;
        logic signed [P_W-1:0] b;
        a = $signed({{(COEF_W + 1){1'b0}}, p});
        b = $signed({{(DATA_W + 1){k[COEF_W-1]}}, k});
        return a * b;
    endfunction

    function automatic logic signed [ACC_W-1:0] sx(
        input logic signed [P_W-1:0] p
    );
        return $signed({{(ACC_W - P_W){p[P_W-1]}}, p});
    endfunction

    assign en           = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = (state == RUN) && en;
    assign accept       = bus.in_valid && bus.in_ready;
    assign flush_end    = bus.out_valid && bus.out_ready && bus.out_last;
    assign bus.busy     = state != IDLE;
    assign bus.done     = state == DONE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (bus.start) state_nx = RUN;
            RUN:     if (accept && last_pix) state_nx = FLUSH;
            FLUSH:   if (flush_end) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 9; i++) kern[i] <= COEF_W'(sobel_x(i));
        end else if (state == IDLE && bus.coef_wr && bus.coef_addr < 4'd9) begin
            kern[bus.coef_addr] <= bus.coef_data;
        end
    end

    conv_line_buffer #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .DATA_W (DATA_W)
    ) u_lb (
        .clk       (clk),
        .rst       (rst),
        .clear     (state == IDLE),
        .en        (en),
        .accept    (accept),
        .pix       (bus.in_data),
        .win       (win),
        .win_valid (win_valid),
        .win_last  (win_last),
        .last_pix  (last_pix)
    );

    assign total = rsum[0] + rsum[1] + rsum[2];

`ifdef CONV_RELU_EN
    assign result = total[ACC_W-1] ? '0 : total;
`else
    assign result = total;
`endif

    // Products, row sums and the output register all freeze together on stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 9; i++) prod[i] <= '0;
            for (int r = 0; r < 3; r++) rsum[r] <= '0;
            prod_valid    <= 1'b0;
            prod_last     <= 1'b0;
            sum_valid     <= 1'b0;
            sum_last      <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            bus.out_data  <= '0;
        end else if (en) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    prod[r*3+c] <= mul(win[r][c], kern[r*3+c]);
                end
                rsum[r] <= sx(prod[r*3]) + sx(prod[r*3+1]) + sx(prod[r*3+2]);
            end
            prod_valid    <= win_valid;
            prod_last     <= win_last;
            sum_valid     <= prod_valid;
            sum_last      <= prod_last;
            bus.out_valid <= sum_valid;
            bus.out_last  <= sum_last;
            bus.out_data  <= result;
        end
    end

endmodule

// File: tb/tb_conv2d_stream_engine.sv
// Scoreboard bench for conv2d_stream_engine on an 8x6 frame.
// Expected results are pushed at pixel issue; a monitor pops on handshake.
module tb_conv2d_stream_engine;
    import conv_pkg::*;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int DW = 8;
    localparam int CW = 8;
    localparam int AW = conv_acc_w(DW, CW);

`ifdef CONV_RELU_EN
    localparam int SOB_EXP = 0;
`else
    localparam int SOB_EXP = -80;
`endif

    localparam int K_NONE = 0;
    localparam int K_SOB  = 1;
    localparam int K_ID   = 2;
    localparam int K_TL   = 3;

    typedef struct packed {
        logic [AW-1:0] d;
        logic          l;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    conv2d_stream_engine_if #(.DATA_W(DW), .COEF_W(CW), .ACC_W(AW)) bus();

    conv2d_stream_engine #(
        .IMG_W  (W),
        .IMG_H  (H),
        .DATA_W (DW),
        .COEF_W (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    bit   bp_en = 1'b0;
    bit   ignore_out = 1'b0;
    int   kset [9];

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: scoreboard pop, stall stability and done pulse.
    initial begin
        logic          stall;
        logic [AW-1:0] hd;
        logic          hl;
        logic          want_done;
        exp_t          e;
        stall = 1'b0;
        want_done = 1'b0;
        hd = '0;
        hl = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                stall = 1'b0;
                want_done = 1'b0;
                continue;
            end
            if (want_done) begin
                check("done_pulse", 64'(bus.done), 1);
                want_done = 1'b0;
            end
            if (stall) begin
                check("stall_valid", 64'(bus.out_valid), 1);
                check("stall_data", $signed(bus.out_data), $signed(hd));
                check("stall_last", 64'(bus.out_last), 64'(hl));
            end
            if (bus.out_valid && !bus.out_ready) begin
                check("stall_in_ready", 64'(bus.in_ready), 0);
                stall = 1'b1;
                hd = bus.out_data;
                hl = bus.out_last;
            end else begin
                stall = 1'b0;
            end
            if (bus.out_valid && bus.out_ready && !ignore_out) begin
                if (q.size() == 0) begin
                    check("unexpected_out", 64'(bus.out_valid), 0);
                end else begin
                    e = q.pop_front();
                    check("out_data", $signed(bus.out_data), $signed(e.d));
                    check("out_last", 64'(bus.out_last), 64'(e.l));
                    if (bus.out_last) want_done = 1'b1;
                end
            end
        end
    end

    function automatic int pix_val(input int pat, input int x, input int y);
        return (pat == 0) ? 10 * x : x + 8 * y;
    endfunction

    function automatic int exp_val(input int kind, input int x, input int y);
        case (kind)
            K_SOB:   return SOB_EXP;
            K_ID:    return (x - 1) + 8 * (y - 1);
            default: return (x - 2) + 8 * (y - 2);
        endcase
    endfunction

    task automatic load_kernel();
        for (int i = 0; i < 9; i++) begin
            bus.coef_wr = 1'b1;
            bus.coef_addr = 4'(i);
            bus.coef_data = CW'(kset[i]);
            tick();
        end
        bus.coef_addr = 4'd13;
        bus.coef_data = 8'h55;
        tick();
        bus.coef_wr = 1'b0;
    endtask

    task automatic run_frame(input int pat, input int kind, input bit bubbles,
                             input bit illegal, input int limit);
        int   n;
        logic acc;
        exp_t e;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                if (y * W + x >= limit) return;
                if (bubbles && $urandom_range(0, 2) == 0) begin
                    bus.in_valid = 1'b0;
                    tick();
                end
                bus.in_valid = 1'b1;
                bus.in_data = DW'(pix_val(pat, x, y));
                if (illegal && y == 1 && x == 2) begin
                    bus.start = 1'b1;
                    bus.coef_wr = 1'b1;
                    bus.coef_addr = 4'd0;
                    bus.coef_data = 8'd5;
                end
                if (kind != K_NONE && x >= 2 && y >= 2) begin
                    e.d = AW'(exp_val(kind, x, y));
                    e.l = (x == W - 1) && (y == H - 1);
                    q.push_back(e);
                end
                n = 0;
                do begin
                    @(negedge clk);
                    acc = bus.in_ready;
                    @(posedge clk);
                    #1;
                    n++;
                end while (!acc && n < 1000);
                if (!acc) check("accept_timeout", 64'(acc), 1);
                bus.start = 1'b0;
                bus.coef_wr = 1'b0;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic finish_frame(input string name);
        int n;
        n = 0;
        while (bus.busy && n < 2000) begin
            tick();
            n++;
        end
        check({name, "_idle"}, 64'(bus.busy), 0);
        check({name, "_drain"}, 64'(q.size()), 0);
        q.delete();
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_in_ready"}, 64'(bus.in_ready), 0);
        check({name, "_out_valid"}, 64'(bus.out_valid), 0);
        check({name, "_out_data"}, 64'(bus.out_data), 0);
        check({name, "_out_last"}, 64'(bus.out_last), 0);
        check({name, "_busy"}, 64'(bus.busy), 0);
        check({name, "_done"}, 64'(bus.done), 0);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.coef_wr = 1'b0;
        bus.coef_addr = '0;
        bus.coef_data = '0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        repeat (3) tick();
        check_reset_outputs("rst0");
        rst = 1'b1;
        tick();

        run_frame(0, K_SOB, 1'b0, 1'b0, W * H);
        finish_frame("sobel");

        kset = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
        load_kernel();
        run_frame(1, K_ID, 1'b0, 1'b0, W * H);
        finish_frame("ident");

        bp_en = 1'b1;
        run_frame(1, K_ID, 1'b0, 1'b0, W * H);
        finish_frame("bp");
        run_frame(1, K_ID, 1'b1, 1'b0, W * H);
        finish_frame("bp_bubble");
        bp_en = 1'b0;

        kset = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
        load_kernel();
        run_frame(1, K_TL, 1'b0, 1'b1, W * H);
        finish_frame("illegal");

        ignore_out = 1'b1;
        run_frame(0, K_NONE, 1'b0, 1'b0, 20);
        bus.in_valid = 1'b0;
        rst = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        tick();
        check_reset_outputs("rst_hold");
        q.delete();
        rst = 1'b1;
        tick();
        ignore_out = 1'b0;
        run_frame(0, K_SOB, 1'b0, 1'b0, W * H);
        finish_frame("after_rst");

        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
